// File: rtl/skinny_masked_pkg.sv
// Shared types and constants for the masked Skinny-64 inverse S-box pipeline.
// SKINNY_INV_SBOX_REFRESH_EN widens the fresh-randomness bus for the output remask stage.
package skinny_masked_pkg;

  // Two Boolean shares of one nibble; the unmasked value is s0 ^ s1.
  typedef struct packed {
    logic [3:0] s0;
    logic [3:0] s1;
  } nib2_t;

  localparam logic [3:0] SKINNY_SBOX [16] = '{
    4'hc, 4'h6, 4'h9, 4'h0, 4'h1, 4'ha, 4'h2, 4'hb,
    4'h3, 4'h8, 4'h5, 4'hd, 4'h4, 4'he, 4'h7, 4'hf
  };

  localparam logic [3:0] SKINNY_INV_SBOX [16] = '{
    4'h3, 4'h4, 4'h6, 4'h8, 4'hc, 4'ha, 4'h1, 4'he,
    4'h9, 4'h2, 4'h5, 4'h7, 4'h0, 4'hb, 4'hd, 4'hf
  };

`ifdef SKINNY_INV_SBOX_REFRESH_EN
  localparam int FRESH_W = 8;
`else
  localparam int FRESH_W = 4;
`endif

endpackage

// File: rtl/dom_and_masked.sv
// Registered two-share DOM-independent AND: q0 ^ q1 = (a0 ^ a1) & (b0 ^ b1), one cycle later.
// Cross-domain products are refreshed with r_i before they are registered.
module dom_and_masked (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic a0_i,
  input  logic a1_i,
  input  logic b0_i,
  input  logic b1_i,
  input  logic r_i,
  output logic q0_o,
  output logic q1_o
);

  logic inner0_q, inner1_q, cross01_q, cross10_q;

  // The register boundary is what stops glitches from recombining the two domains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inner0_q  <= 1'b0;
      inner1_q  <= 1'b0;
      cross01_q <= 1'b0;
      cross10_q <= 1'b0;
    end else if (en_i) begin
      inner0_q  <= a0_i & b0_i;
      inner1_q  <= a1_i & b1_i;
      cross01_q <= (a0_i & b1_i) ^ r_i;
      cross10_q <= (a1_i & b0_i) ^ r_i;
    end
  end

  assign q0_o = inner0_q ^ cross01_q;
  assign q1_o = inner1_q ^ cross10_q;

endmodule

// File: rtl/skinny_inv_sbox_masked_pipe.sv
// First-order masked Skinny-64 inverse S-box: rotate-left, then four registered NOR/XOR layers.
// SKINNY_INV_SBOX_REFRESH_EN adds a registered output remask stage driven by Fresh[7:4].
module skinny_inv_sbox_masked_pipe
  import skinny_masked_pkg::*;
#(
  parameter int REG_INPUT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               in_valid,
  input  logic [3:0]         SI_s0,
  input  logic [3:0]         SI_s1,
  input  logic [FRESH_W-1:0] Fresh,
  output logic               out_valid,
  output logic [3:0]         SO_s0,
  output logic [3:0]         SO_s1
);

  // Layer k computes bit TGT[k] ^= NOR(bit OPA[k], bit OPB[k]); this undoes the forward
  // decomposition in reverse order, after undoing its final rotate-right.
  localparam int TGT [4] = '{1, 2, 3, 0};
  localparam int OPA [4] = '{3, 1, 2, 3};
  localparam int OPB [4] = '{0, 0, 1, 2};

  nib2_t si_in;
  logic  vld_in;

  generate
    if (REG_INPUT != 0) begin : g_in_reg
      nib2_t si_q;
      logic  vld_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          si_q  <= '0;
          vld_q <= 1'b0;
        end else if (en) begin
          si_q  <= '{s0: SI_s0, s1: SI_s1};
          vld_q <= in_valid;
        end
      end
      assign si_in  = si_q;
      assign vld_in = vld_q;
    end else begin : g_in_comb
      assign si_in  = '{s0: SI_s0, s1: SI_s1};
      assign vld_in = in_valid;
    end
  endgenerate

  nib2_t stage [5];
  logic  vld   [5];

  assign stage[0] = '{s0: {si_in.s0[2:0], si_in.s0[3]}, s1: {si_in.s1[2:0], si_in.s1[3]}};
  assign vld[0]   = vld_in;

  generate
    for (genvar k = 0; k < 4; k++) begin : g_layer
      nib2_t st_q;
      logic  vld_q;
      logic  and0, and1;
      nib2_t st_out;

      // Negating a shared bit flips share 0 only, so NOR becomes an AND of inverted operands.
      dom_and_masked u_and (
        .clk  (clk),
        .rst_n(rst_n),
        .en_i (en),
        .a0_i (~stage[k].s0[OPA[k]]),
        .a1_i (stage[k].s1[OPA[k]]),
        .b0_i (~stage[k].s0[OPB[k]]),
        .b1_i (stage[k].s1[OPB[k]]),
        .r_i  (Fresh[k]),
        .q0_o (and0),
        .q1_o (and1)
      );

      // NOTE: data registers are reset too, so SO reads zero while rst_n is low.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          st_q  <= '0;
          vld_q <= 1'b0;
        end else if (en) begin
          st_q  <= stage[k];
          vld_q <= vld[k];
        end
      end

      // NOTE: default copy first, then patch the target bit, so no latch is inferred.
      always_comb begin
        st_out = st_q;
        st_out.s0[TGT[k]] = st_q.s0[TGT[k]] ^ and0;
        st_out.s1[TGT[k]] = st_q.s1[TGT[k]] ^ and1;
      end

      assign stage[k+1] = st_out;
      assign vld[k+1]   = vld_q;
    end
  endgenerate

`ifdef SKINNY_INV_SBOX_REFRESH_EN
  nib2_t so_q;
  logic  ov_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      so_q <= '0;
      ov_q <= 1'b0;
    end else if (en) begin
      so_q <= '{s0: stage[4].s0 ^ Fresh[7:4], s1: stage[4].s1 ^ Fresh[7:4]};
      ov_q <= vld[4];
    end
  end

  assign SO_s0     = so_q.s0;
  assign SO_s1     = so_q.s1;
  assign out_valid = ov_q;
`else
  assign SO_s0     = stage[4].s0;
  assign SO_s1     = stage[4].s1;
  assign out_valid = vld[4];
`endif

endmodule

// File: tb/tb_skinny_inv_sbox_masked_pipe.sv
// Self-checking bench for skinny_inv_sbox_masked_pipe: table-driven vectors plus stall,
// reset, masking-statistics and (with SKINNY_INV_SBOX_REFRESH_EN) remask sequences.
`timescale 1ns/1ps
module tb_skinny_inv_sbox_masked_pipe;

  localparam int REG_IN = 0;
`ifdef SKINNY_INV_SBOX_REFRESH_EN
  localparam int FW  = 8;
  localparam int LAT = 5 + REG_IN;
`else
  localparam int FW  = 4;
  localparam int LAT = 4 + REG_IN;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          in_valid;
  logic [3:0]    si0, si1;
  logic [FW-1:0] fresh;
  logic          out_valid;
  logic [3:0]    so0, so1;

  always #5 clk = ~clk;

  skinny_inv_sbox_masked_pipe #(.REG_INPUT(REG_IN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_valid (in_valid),
    .SI_s0    (si0),
    .SI_s1    (si1),
    .Fresh    (fresh),
    .out_valid(out_valid),
    .SO_s0    (so0),
    .SO_s1    (so1)
  );

  typedef struct {
    logic [3:0] x;
    logic [3:0] inv;
    logic [3:0] fwd;
  } vec_t;

  vec_t tbl [16];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] x);
    logic [3:0] m;
    m        = 4'($urandom);
    in_valid = v;
    si0      = m;
    si1      = x ^ m;
    fresh    = FW'($urandom);
  endtask

  task automatic drain();
    en = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      drive(1'b0, 4'h0);
      step();
    end
  endtask

  // Streams all 16 entries back to back and checks each result lands exactly LAT cycles later.
  task automatic run_table(input bit round_trip);
    int idx;
    en = 1'b1;
    for (int c = 0; c < 16 + LAT; c++) begin
      if (c < 16) drive(1'b1, round_trip ? tbl[c].fwd : tbl[c].x);
      else        drive(1'b0, 4'h0);
      step();
      if (c >= LAT - 1) begin
        idx = c - LAT + 1;
        if (idx < 16) begin
          check($sformatf("%s_valid[%0d]", round_trip ? "rt" : "inv", idx), 16'(out_valid), 16'd1);
          check($sformatf("%s_value[%0d]", round_trip ? "rt" : "inv", idx), 16'(so0 ^ so1),
                16'(round_trip ? tbl[idx].x : tbl[idx].inv));
        end else begin
          check($sformatf("%s_valid_after", round_trip ? "rt" : "inv"), 16'(out_valid), 16'd0);
        end
      end else begin
        check($sformatf("%s_valid_early[%0d]", round_trip ? "rt" : "inv", c), 16'(out_valid), 16'd0);
      end
    end
  endtask

  initial begin
    logic [3:0]  inv_ref [16];
    logic [3:0]  fwd_ref [16];
    logic [3:0]  got [$];
    logic [15:0] held;
    int          hist [16];
    int          n_samp, n_bad;
    real         chi2, e;

    inv_ref = '{4'h3, 4'h4, 4'h6, 4'h8, 4'hc, 4'ha, 4'h1, 4'he,
                4'h9, 4'h2, 4'h5, 4'h7, 4'h0, 4'hb, 4'hd, 4'hf};
    fwd_ref = '{4'hc, 4'h6, 4'h9, 4'h0, 4'h1, 4'ha, 4'h2, 4'hb,
                4'h3, 4'h8, 4'h5, 4'hd, 4'h4, 4'he, 4'h7, 4'hf};
    for (int i = 0; i < 16; i++) begin
      tbl[i].x   = 4'(i);
      tbl[i].inv = inv_ref[i];
      tbl[i].fwd = fwd_ref[i];
    end

    // Reset state, with live stimulus toggling underneath.
    rst_n = 1'b0;
    en    = 1'b1;
    drive(1'b1, 4'h7);
    step();
    step();
    check("reset_out_valid", 16'(out_valid), 16'd0);
    check("reset_so", {8'h00, so0, so1}, 16'h0000);
    rst_n = 1'b1;
    drain();

    run_table(1'b0);
    run_table(1'b1);
    drain();

    // Stall: 0x1, 0x2, then three en=0 cycles, then 0x3.
    got.delete();
    en = 1'b1;
    drive(1'b1, 4'h1);
    step();
    if (out_valid) got.push_back(so0 ^ so1);
    drive(1'b1, 4'h2);
    step();
    if (out_valid) got.push_back(so0 ^ so1);
    held = {7'h00, out_valid, so0, so1};
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'hf);
      step();
      check($sformatf("stall_hold[%0d]", i), {7'h00, out_valid, so0, so1}, held);
    end
    en = 1'b1;
    drive(1'b1, 4'h3);
    step();
    if (out_valid) got.push_back(so0 ^ so1);
    for (int i = 0; i < LAT + 4; i++) begin
      drive(1'b0, 4'h0);
      step();
      if (out_valid) got.push_back(so0 ^ so1);
    end
    check("stall_count", 16'(got.size()), 16'd3);
    if (got.size() >= 3) begin
      check("stall_out0", 16'(got[0]), 16'h4);
      check("stall_out1", 16'(got[1]), 16'h6);
      check("stall_out2", 16'(got[2]), 16'h8);
    end

    // Reset with nibbles in flight and one result already at the output.
    for (int i = 0; i < LAT + 1; i++) begin
      drive(1'b1, 4'(i + 5));
      step();
    end
    check("pre_reset_valid", 16'(out_valid), 16'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", 16'(out_valid), 16'd0);
    check("async_reset_so", {8'h00, so0, so1}, 16'h0000);
    step();
    drive(1'b0, 4'h0);
    step();
    rst_n = 1'b1;
    n_bad = 0;
    for (int i = 0; i < LAT + 2; i++) begin
      step();
      if (out_valid) n_bad++;
    end
    check("no_stale_valid", 16'(n_bad), 16'd0);
    drive(1'b1, 4'hc);
    for (int i = 0; i < LAT; i++) begin
      step();
      drive(1'b0, 4'h0);
      if (i < LAT - 1) check($sformatf("post_reset_early[%0d]", i), 16'(out_valid), 16'd0);
    end
    check("post_reset_valid", 16'(out_valid), 16'd1);
    check("post_reset_value", 16'(so0 ^ so1), 16'h0);
    drain();

    // Masking sanity: fixed 0x5, random shares and Fresh every cycle.
    for (int b = 0; b < 16; b++) hist[b] = 0;
    n_samp = 0;
    n_bad  = 0;
    for (int c = 0; c < 1000 + LAT; c++) begin
      drive(c < 1000, 4'h5);
      step();
      if (out_valid) begin
        n_samp++;
        hist[so0]++;
        if ((so0 ^ so1) !== 4'ha) n_bad++;
      end
    end
    check("mask_samples", 16'(n_samp), 16'd1000);
    check("mask_unmasked_errors", 16'(n_bad), 16'd0);
    chi2 = 0.0;
    e    = 1000.0 / 16.0;
    for (int b = 0; b < 16; b++) chi2 += (real'(hist[b]) - e) * (real'(hist[b]) - e) / e;
    check("mask_chi2_ok", 16'(chi2 < 37.7), 16'd1);
    drain();

`ifdef SKINNY_INV_SBOX_REFRESH_EN
    // Constant shares and Fresh[3:0]: only Fresh[7:4] at the last edge may change SO_s0.
    begin
      logic [3:0] a0, a1;
      in_valid = 1'b1;
      si0      = 4'h3;
      si1      = 4'h6;
      fresh    = 8'h09;
      for (int i = 0; i < LAT + 1; i++) step();
      a0    = so0;
      a1    = so1;
      fresh = 8'h69;
      step();
      check("remask_s0_delta", 16'(so0 ^ a0), 16'h6);
      check("remask_unmasked", 16'(so0 ^ so1), 16'(a0 ^ a1));
      check("remask_value", 16'(so0 ^ so1), 16'ha);
      drain();
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
